// File: rtl/beat_sched_ctrl.sv
// Beat detector sequencer: synchronises the frame clock, sums band levels through one adder,
// compares against running average plus threshold and runs the refractory phase counter.
module beat_sched_ctrl #(
  parameter int NBANDS      = 3,
  parameter int BAND_W      = 4,
  parameter int SUM_W       = 7,
  parameter int THRESH_INIT = 7,
  parameter int HOLDOFF     = 15,
  parameter int AVG_SHIFT   = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_frame_clk,
  input  logic [NBANDS*BAND_W-1:0] i_data,
  input  logic                     i_thresh_we,
  input  logic [SUM_W-1:0]         i_thresh,
  output logic                     o_beat_pulse,
  output logic [3:0]               o_beat_phase,
  output logic [SUM_W-1:0]         o_energy,
  output logic                     o_busy,
  output logic                     o_miss
);

  // state | meaning
  // IDLE  | waiting for a frame tick
  // ACC   | adding one captured band per cycle
  // CMP   | publish energy, beat decision, average and phase update
  typedef enum logic [1:0] {IDLE, ACC, CMP} state_t;

  localparam int IDX_W = (NBANDS > 1) ? $clog2(NBANDS) : 1;
  localparam int AVG_W = SUM_W + AVG_SHIFT;

  state_t                     state;
  logic                       sync1, sync2, frame_prev, tick;
  logic [NBANDS*BAND_W-1:0]   hold;
  logic [SUM_W-1:0]           acc;
  logic [SUM_W-1:0]           thresh;
  logic [IDX_W-1:0]           idx;
  logic [AVG_W-1:0]           avg_acc;
  logic [SUM_W-1:0]           avg;
  logic [BAND_W-1:0]          band;
  logic                       beat_now;
  logic signed [AVG_W:0]      avg_next;

  assign avg  = avg_acc[AVG_W-1:AVG_SHIFT];
  assign band = hold[idx*BAND_W +: BAND_W];

  // Threshold add is one bit wider than the energy so avg+thresh cannot wrap.
  assign beat_now = (o_beat_phase == 4'd0) &&
                    ({1'b0, acc} >= ({1'b0, avg} + {1'b0, thresh}));

  assign avg_next = $signed({1'b0, avg_acc})
                  + $signed({{(AVG_SHIFT+1){1'b0}}, acc})
                  - $signed({{(AVG_SHIFT+1){1'b0}}, avg});

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      frame_prev   <= 1'b0;
      tick         <= 1'b0;
      hold         <= '0;
      acc          <= '0;
      idx          <= '0;
      thresh       <= SUM_W'(THRESH_INIT);
      avg_acc      <= '0;
      o_beat_pulse <= 1'b0;
      o_beat_phase <= 4'd0;
      o_energy     <= '0;
      o_miss       <= 1'b0;
    end else begin
      sync1      <= i_frame_clk;
      sync2      <= sync1;
      frame_prev <= sync2;
      tick       <= sync2 & ~frame_prev;

      if (i_thresh_we)
        thresh <= i_thresh;

      o_beat_pulse <= 1'b0;
      // A tick seen while ACC/CMP is dropped, not queued.
      o_miss       <= tick && (state != IDLE);

      case (state)
        IDLE: begin
          if (tick) begin
            hold  <= i_data;
            acc   <= '0;
            idx   <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          acc <= acc + {{(SUM_W-BAND_W){1'b0}}, band};
          if (idx == IDX_W'(NBANDS-1))
            state <= CMP;
          else
            idx <= idx + 1'b1;
        end
        CMP: begin
          o_energy     <= acc;
          o_beat_pulse <= beat_now;
          avg_acc      <= avg_next[AVG_W] ? '0 : avg_next[AVG_W-1:0];
          if (beat_now)
            o_beat_phase <= 4'd1;
          else if (o_beat_phase != 4'd0)
            o_beat_phase <= (o_beat_phase == 4'(HOLDOFF)) ? 4'd0 : o_beat_phase + 4'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beat_sched_ctrl.sv
// Directed bench for beat_sched_ctrl: frame vectors with hand-computed energy/pulse/phase,
// plus reset-abort and overrun sequences.
module tb_beat_sched_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic        i_frame_clk;
  logic [11:0] i_data;
  logic        i_thresh_we;
  logic [6:0]  i_thresh;
  logic        o_beat_pulse;
  logic [3:0]  o_beat_phase;
  logic [6:0]  o_energy;
  logic        o_busy;
  logic        o_miss;

  int n_vec  = 0;
  int n_miss = 0;

  beat_sched_ctrl dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_frame_clk  (i_frame_clk),
    .i_data       (i_data),
    .i_thresh_we  (i_thresh_we),
    .i_thresh     (i_thresh),
    .o_beat_pulse (o_beat_pulse),
    .o_beat_phase (o_beat_phase),
    .o_energy     (o_energy),
    .o_busy       (o_busy),
    .o_miss       (o_miss)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst;
    logic [11:0] data;
    logic [11:0] acc_data;
    logic        wr;
    logic [6:0]  wthr;
    logic        exp_pulse;
    logic [6:0]  exp_energy;
    logic [3:0]  exp_phase;
  } vec_t;

  vec_t vecs [0:22];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    i_frame_clk = 1'b0;
    i_thresh_we = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic do_frame(input int k, input vec_t v);
    logic seen;
    seen = 1'b0;
    @(negedge i_clk);
    i_data = v.data;
    i_frame_clk = 1'b1;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge i_clk);
      if (o_busy) seen = 1'b1;
    end
    chk($sformatf("v%0d busy_rise", k), int'(seen), 1);
    if (seen) begin
      i_data = v.acc_data;
      repeat (3) @(negedge i_clk);
      chk($sformatf("v%0d pulse_early", k), int'(o_beat_pulse), 0);
      if (v.wr) begin
        i_thresh_we = 1'b1;
        i_thresh = v.wthr;
      end
      @(negedge i_clk);
      i_thresh_we = 1'b0;
      chk($sformatf("v%0d pulse", k), int'(o_beat_pulse), int'(v.exp_pulse));
      chk($sformatf("v%0d energy", k), int'(o_energy), int'(v.exp_energy));
      chk($sformatf("v%0d phase", k), int'(o_beat_phase), int'(v.exp_phase));
      chk($sformatf("v%0d busy_low", k), int'(o_busy), 0);
      @(negedge i_clk);
      chk($sformatf("v%0d pulse_width", k), int'(o_beat_pulse), 0);
    end
    i_frame_clk = 1'b0;
    repeat (4) @(negedge i_clk);
  endtask

  initial begin
    int rise_at, fall_at, misses, pulses;
    logic busy_q, any_pulse, any_busy;

    i_rst = 1'b1;
    i_frame_clk = 1'b0;
    i_data = '0;
    i_thresh_we = 1'b0;
    i_thresh = '0;

    //            rst  data     acc_data wr wthr  pulse E   phase
    vecs[0]  = '{1'b1, 12'h321, 12'h321, 1'b0, 7'd0,  1'b0, 7'd6,  4'd0};
    vecs[1]  = '{1'b0, 12'h555, 12'h0A3, 1'b0, 7'd0,  1'b1, 7'd15, 4'd1};
    vecs[2]  = '{1'b1, 12'hFFF, 12'hFFF, 1'b0, 7'd0,  1'b1, 7'd45, 4'd1};
    for (int k = 0; k < 14; k++)
      vecs[3+k] = '{1'b0, 12'hFFF, 12'hFFF, 1'b0, 7'd0, 1'b0, 7'd45, 4'(k+2)};
    vecs[17] = '{1'b0, 12'hFFF, 12'hFFF, 1'b0, 7'd0,  1'b0, 7'd45, 4'd0};
    // avg_acc=320 here, avg=40: 45 < 47 so no pulse on the re-armed frame
    vecs[18] = '{1'b0, 12'hFFF, 12'hFFF, 1'b0, 7'd0,  1'b0, 7'd45, 4'd0};
    vecs[19] = '{1'b1, 12'hFFF, 12'hFFF, 1'b1, 7'd60, 1'b1, 7'd45, 4'd1};
    vecs[20] = '{1'b1, 12'h222, 12'h222, 1'b1, 7'd60, 1'b0, 7'd6,  4'd0};
    vecs[21] = '{1'b0, 12'hFFF, 12'h111, 1'b0, 7'd0,  1'b0, 7'd45, 4'd0};
    vecs[22] = '{1'b1, 12'h133, 12'h133, 1'b0, 7'd0,  1'b1, 7'd7,  4'd1};

    #1;
    chk("rst pulse", int'(o_beat_pulse), 0);
    chk("rst phase", int'(o_beat_phase), 0);
    chk("rst energy", int'(o_energy), 0);
    chk("rst busy", int'(o_busy), 0);
    chk("rst miss", int'(o_miss), 0);

    for (int k = 0; k < 23; k++) begin
      if (vecs[k].rst) apply_reset();
      do_frame(k, vecs[k]);
    end

    // Reset mid-ACC after raising the threshold: abort, outputs clear, threshold back to 7.
    @(negedge i_clk);
    i_thresh_we = 1'b1;
    i_thresh = 7'd20;
    @(negedge i_clk);
    i_thresh_we = 1'b0;
    i_data = 12'hFFF;
    i_frame_clk = 1'b1;
    any_busy = 1'b0;
    for (int n = 0; n < 8 && !any_busy; n++) begin
      @(negedge i_clk);
      if (o_busy) any_busy = 1'b1;
    end
    chk("abort busy_rise", int'(any_busy), 1);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("abort pulse", int'(o_beat_pulse), 0);
    chk("abort phase", int'(o_beat_phase), 0);
    chk("abort energy", int'(o_energy), 0);
    chk("abort busy", int'(o_busy), 0);
    i_frame_clk = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    any_pulse = 1'b0;
    any_busy = 1'b0;
    repeat (10) begin
      @(negedge i_clk);
      any_pulse |= o_beat_pulse;
      any_busy |= o_busy;
    end
    chk("abort no_pulse", int'(any_pulse), 0);
    chk("abort idle", int'(any_busy), 0);
    do_frame(100, '{1'b0, 12'h133, 12'h133, 1'b0, 7'd0, 1'b1, 7'd7, 4'd1});

    // Overrun: a second frame edge lands while the first frame is still accumulating.
    apply_reset();
    @(negedge i_clk);
    i_data = 12'h555;
    i_frame_clk = 1'b1;
    @(negedge i_clk);
    i_frame_clk = 1'b0;
    @(negedge i_clk);
    i_frame_clk = 1'b1;
    rise_at = -1;
    fall_at = -1;
    misses = 0;
    pulses = 0;
    busy_q = 1'b0;
    for (int n = 0; n < 14; n++) begin
      @(negedge i_clk);
      if (o_busy && !busy_q && rise_at < 0) rise_at = n;
      if (!o_busy && busy_q && fall_at < 0) fall_at = n;
      if (o_miss) misses++;
      if (o_beat_pulse) pulses++;
      busy_q = o_busy;
    end
    chk("overrun busy_rise_seen", int'(rise_at >= 0), 1);
    chk("overrun busy_len", fall_at - rise_at, 4);
    chk("overrun miss_count", misses, 1);
    chk("overrun pulse_count", pulses, 1);
    chk("overrun energy", int'(o_energy), 15);
    chk("overrun idle_after", int'(o_busy), 0);
    i_frame_clk = 1'b0;
    repeat (4) @(negedge i_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
